// File: rtl/snake_sound_pkg.sv
// Shared types for the snake sound path.
// MODE_TYPES : oscillator on/off state (also used by the oscillator).
// SOUND_T    : sound event id; the numeric value is the priority.
// seq_state_t: sequencer FSM states.
package snake_sound_pkg;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } MODE_TYPES;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    EAT   = 2'd1,
    WIN   = 2'd2,
    CRASH = 2'd3
  } SOUND_T;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } seq_state_t;

  localparam int MAX_NOTES = 4;
  localparam int IDX_W     = $clog2(MAX_NOTES);

endpackage

// File: rtl/snake_sound_rom.sv
// Melody ROM: note table for each sound, {frequency in Hz, duration in units}.
// Ports:
//   id_i   - melody selector
//   idx_i  - note index within the melody
//   freq_o - note frequency (never 0)
//   dur_o  - note duration in units
//   last_o - this is the final note of the melody
// Unused id/index combinations return a short safe note marked last.
module snake_sound_rom
  import snake_sound_pkg::*;
#(
  parameter int DUR_W = 5
) (
  input  SOUND_T           id_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [8:0]       freq_o,
  output logic [DUR_W-1:0] dur_o,
  output logic             last_o
);

  // Note lookup; defaults form the fallback note.
  always_comb begin
    freq_o = 9'd262;
    dur_o  = DUR_W'(1);
    last_o = 1'b1;
    case (id_i)
      EAT: begin
        case (idx_i)
          2'd0:    begin freq_o = 9'd392; dur_o = DUR_W'(5);  last_o = 1'b0; end
          2'd1:    begin freq_o = 9'd523; dur_o = DUR_W'(5);  last_o = 1'b1; end
          default: begin freq_o = 9'd262; dur_o = DUR_W'(1);  last_o = 1'b1; end
        endcase
      end
      WIN: begin
        case (idx_i)
          2'd0:    begin freq_o = 9'd262; dur_o = DUR_W'(8);  last_o = 1'b0; end
          2'd1:    begin freq_o = 9'd330; dur_o = DUR_W'(8);  last_o = 1'b0; end
          2'd2:    begin freq_o = 9'd392; dur_o = DUR_W'(8);  last_o = 1'b0; end
          2'd3:    begin freq_o = 9'd523; dur_o = DUR_W'(16); last_o = 1'b1; end
          default: begin freq_o = 9'd262; dur_o = DUR_W'(1);  last_o = 1'b1; end
        endcase
      end
      CRASH: begin
        case (idx_i)
          2'd0:    begin freq_o = 9'd220; dur_o = DUR_W'(10); last_o = 1'b0; end
          2'd1:    begin freq_o = 9'd196; dur_o = DUR_W'(10); last_o = 1'b0; end
          2'd2:    begin freq_o = 9'd165; dur_o = DUR_W'(20); last_o = 1'b1; end
          default: begin freq_o = 9'd262; dur_o = DUR_W'(1);  last_o = 1'b1; end
        endcase
      end
      default: begin
        freq_o = 9'd262;
        dur_o  = DUR_W'(1);
        last_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/snake_sound_sequencer.sv
// Snake game sound sequencer: arbitrates eat/win/crash requests by fixed
// priority and plays the chosen melody note by note on the tone oscillator.
// Ports:
//   clk, nRst          - clock, asynchronous active-low reset
//   req_eat/win/crash  - one-cycle sound requests from the game FSM
//   mute               - suppresses playSound only
//   freq, mode         - oscillator frequency and on/off state
//   playSound          - oscillator enable
//   busy, cur_sound    - melody in progress and which one
//   done               - one-cycle pulse when a melody finishes naturally
module snake_sound_sequencer
  import snake_sound_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int DUR_W    = 5
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       req_eat,
  input  logic       req_win,
  input  logic       req_crash,
  input  logic       mute,
  output logic [8:0] freq,
  output MODE_TYPES  mode,
  output logic       playSound,
  output logic       busy,
  output SOUND_T     cur_sound,
  output logic       done
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICK_DIV - 1);

  seq_state_t       state_q, state_d;
  SOUND_T           sound_q, sound_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [DUR_W-1:0] unit_q, unit_d;
  logic [DUR_W-1:0] dur_q;
  logic             last_q;
  logic [8:0]       freq_q, freq_d;
  MODE_TYPES        mode_q, mode_d;
  logic             play_q, play_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  SOUND_T           req_s;
  logic             preempt_s;
  logic [8:0]       rom_freq_s;
  logic [DUR_W-1:0] rom_dur_s;
  logic             rom_last_s;

  // Fixed-priority request encoding; the enum value is the priority.
  always_comb begin
    if (req_crash) begin
      req_s = CRASH;
    end else if (req_win) begin
      req_s = WIN;
    end else if (req_eat) begin
      req_s = EAT;
    end else begin
      req_s = NONE;
    end
  end

  // In IDLE cur_sound is NONE, so a start is just a preemption of nothing.
  assign preempt_s = (req_s > sound_q);

  // The ROM reads the next note so freq/dur/last register alongside it.
  snake_sound_rom #(.DUR_W(DUR_W)) u_rom (
    .id_i   (sound_d),
    .idx_i  (idx_d),
    .freq_o (rom_freq_s),
    .dur_o  (rom_dur_s),
    .last_o (rom_last_s)
  );

  // Next-state, counter and output decode.
  always_comb begin
    state_d = state_q;
    sound_d = sound_q;
    idx_d   = idx_q;
    pre_d   = pre_q;
    unit_d  = unit_q;
    done_d  = 1'b0;
    if (preempt_s) begin
      state_d = PLAY;
      sound_d = req_s;
      idx_d   = '0;
      pre_d   = '0;
      unit_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          sound_d = NONE;
        end
        PLAY: begin
          if (pre_q == TICK_LAST) begin
            pre_d = '0;
            // Expiry is checked before incrementing, so unit_q never wraps.
            if (unit_q == (dur_q - DUR_W'(1))) begin
              unit_d = '0;
              if (last_q) begin
                state_d = IDLE;
                sound_d = NONE;
                idx_d   = '0;
                done_d  = 1'b1;
              end else begin
                state_d = GAP;
              end
            end else begin
              unit_d = unit_q + DUR_W'(1);
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        GAP: begin
          if (pre_q == TICK_LAST) begin
            pre_d   = '0;
            state_d = PLAY;
            idx_d   = idx_q + IDX_W'(1);
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          sound_d = NONE;
          idx_d   = '0;
          pre_d   = '0;
          unit_d  = '0;
        end
      endcase
    end

    // GAP keeps the note's frequency; only IDLE returns freq to 0.
    if (state_d == IDLE) begin
      freq_d = 9'd0;
    end else begin
      freq_d = rom_freq_s;
    end
    if (state_d == PLAY) begin
      mode_d = ON;
      play_d = 1'b1;
    end else begin
      mode_d = OFF;
      play_d = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      sound_q <= NONE;
      idx_q   <= '0;
      pre_q   <= '0;
      unit_q  <= '0;
      dur_q   <= '0;
      last_q  <= 1'b0;
      freq_q  <= 9'd0;
      mode_q  <= OFF;
      play_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sound_q <= sound_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      unit_q  <= unit_d;
      dur_q   <= rom_dur_s;
      last_q  <= rom_last_s;
      freq_q  <= freq_d;
      mode_q  <= mode_d;
      play_q  <= play_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign freq      = freq_q;
  assign mode      = mode_q;
  assign playSound = play_q & ~mute;
  assign busy      = busy_q;
  assign cur_sound = sound_q;
  assign done      = done_q;

endmodule

// File: tb/tb_snake_sound_sequencer.sv
// Scoreboard bench for snake_sound_sequencer with TICK_DIV=4.
// Each request pushes the full expected per-cycle output trace of its melody;
// every negedge pops one entry and compares it with the DUT outputs.
module tb_snake_sound_sequencer;
  import snake_sound_pkg::*;

  localparam int TD = 4;

  logic       clk;
  logic       nRst;
  logic       req_eat, req_win, req_crash, mute;
  logic [8:0] freq;
  MODE_TYPES  mode;
  logic       playSound, busy, done;
  SOUND_T     cur_sound;

  // {freq[8:0], mode, play, busy, cur[1:0], done}
  logic [14:0] sb_q[$];
  localparam logic [14:0] IDLE_V = 15'd0;
  localparam logic [14:0] DONE_V = 15'd1;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  snake_sound_sequencer #(.TICK_DIV(TD), .DUR_W(5)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .req_eat   (req_eat),
    .req_win   (req_win),
    .req_crash (req_crash),
    .mute      (mute),
    .freq      (freq),
    .mode      (mode),
    .playSound (playSound),
    .busy      (busy),
    .cur_sound (cur_sound),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int n_notes(input logic [1:0] snd);
    case (snd)
      2'd1:    return 2;
      2'd2:    return 4;
      2'd3:    return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [8:0] note_f(input logic [1:0] snd, input int i);
    case (snd)
      2'd1:    return (i == 0) ? 9'd392 : 9'd523;
      2'd2:    return (i == 0) ? 9'd262 : (i == 1) ? 9'd330 : (i == 2) ? 9'd392 : 9'd523;
      2'd3:    return (i == 0) ? 9'd220 : (i == 1) ? 9'd196 : 9'd165;
      default: return 9'd0;
    endcase
  endfunction

  function automatic int note_d(input logic [1:0] snd, input int i);
    case (snd)
      2'd1:    return 5;
      2'd2:    return (i == 3) ? 16 : 8;
      2'd3:    return (i == 2) ? 20 : 10;
      default: return 0;
    endcase
  endfunction

  // Push the complete expected trace of one melody, ending with the done cycle.
  task automatic push_melody(input logic [1:0] snd, input logic muted);
    int n;
    n = n_notes(snd);
    for (int i = 0; i < n; i++) begin
      repeat (note_d(snd, i) * TD) sb_q.push_back({note_f(snd, i), 1'b1, ~muted, 1'b1, snd, 1'b0});
      if (i < n - 1) begin
        repeat (TD) sb_q.push_back({note_f(snd, i), 1'b0, 1'b0, 1'b1, snd, 1'b0});
      end
    end
    sb_q.push_back(DONE_V);
  endtask

  // One cycle: compare outputs at negedge against the next scoreboard entry.
  task automatic step(input string name);
    logic [14:0] exp_v, act_v;
    @(negedge clk);
    cyc++;
    if (sb_q.size() > 0) exp_v = sb_q.pop_front();
    else exp_v = IDLE_V;
    act_v = {freq, mode, playSound, busy, cur_sound, done};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_mis++;
      $display("FAIL %s cycle %0d: got freq=%0d mode=%0d play=%0d busy=%0d cur=%0d done=%0d, expected freq=%0d mode=%0d play=%0d busy=%0d cur=%0d done=%0d",
               name, cyc, act_v[14:6], act_v[5], act_v[4], act_v[3], act_v[2:1], act_v[0],
               exp_v[14:6], exp_v[5], exp_v[4], exp_v[3], exp_v[2:1], exp_v[0]);
    end
    req_eat = 1'b0;
    req_win = 1'b0;
    req_crash = 1'b0;
  endtask

  task automatic run(input string name, input int n);
    for (int i = 0; i < n; i++) step(name);
  endtask

  task automatic check_reset_now(input string name);
    logic [14:0] act_v;
    act_v = {freq, mode, playSound, busy, cur_sound, done};
    n_cmp++;
    if (act_v !== IDLE_V) begin
      n_mis++;
      $display("FAIL %s: got outputs %h, expected reset value %h", name, act_v, IDLE_V);
    end
  endtask

  task automatic test_reset;
    nRst = 1'b0;
    req_eat = 1'b0; req_win = 1'b0; mute = 1'b0;
    req_crash = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_reset_now("reset_hold");
    end
    nRst = 1'b1;
    #1;
    check_reset_now("reset_release");
    push_melody(2'd3, 1'b0);
    run("reset_crash", sb_q.size() + 2);
  endtask

  task automatic test_eat;
    req_eat = 1'b1;
    push_melody(2'd1, 1'b0);
    run("eat", sb_q.size() + 2);
  endtask

  task automatic test_same_cycle;
    req_eat = 1'b1;
    req_win = 1'b1;
    push_melody(2'd2, 1'b0);
    run("same_cycle", sb_q.size() + 2);
  endtask

  task automatic test_preempt;
    req_win = 1'b1;
    push_melody(2'd2, 1'b0);
    run("preempt_win", 80);
    req_crash = 1'b1;
    sb_q.delete();
    push_melody(2'd3, 1'b0);
    run("preempt_crash", 20);
    req_eat = 1'b1;
    run("preempt_low_drop", 10);
    req_crash = 1'b1;
    run("preempt_equal_drop", sb_q.size() + 2);
  endtask

  task automatic test_mute;
    mute = 1'b1;
    req_win = 1'b1;
    push_melody(2'd2, 1'b1);
    run("mute", sb_q.size() + 2);
    mute = 1'b0;
  endtask

  task automatic test_async_reset;
    req_crash = 1'b1;
    push_melody(2'd3, 1'b0);
    run("areset_crash", 50);
    #2;
    nRst = 1'b0;
    #1;
    check_reset_now("areset_immediate");
    sb_q.delete();
    @(negedge clk);
    check_reset_now("areset_held");
    nRst = 1'b1;
    run("areset_idle", 2);
    req_eat = 1'b1;
    push_melody(2'd1, 1'b0);
    run("areset_eat", sb_q.size() + 2);
  endtask

  initial begin
    test_reset();
    test_eat();
    test_same_cycle();
    test_preempt();
    test_mute();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
